tdp_ram36k_sc: RTL and testbench
================================

// Module: tdp_ram36k_sc
// PURPOSE
// - True dual-port 36Kb block RAM (1024 x 36: 32 data + 4 parity bits), ports A and B, single shared clock.
// - Both ports independently read/write with per-port configurable width.
// - Used as the generic on-chip RAM primitive behind FIFOs and buffers.
// PARAMETERS
// - WRITE_WIDTH_A  36  port A write width; one of 9, 18, 36
// - READ_WIDTH_A   36  port A read width; must equal WRITE_WIDTH_A
// - WRITE_WIDTH_B  36  port B write width; one of 9, 18, 36
// - READ_WIDTH_B   36  port B read width; must equal WRITE_WIDTH_B
// - Any other value, or read width != write width on a port: elaboration error.
// PORTS
// - CLK                  in   1   single clock for both ports; all activity on rising edge
// - RST_N                in   1   asynchronous active-low reset; clears output registers only
// - WEN_A / WEN_B        in   1   write enable, active high
// - REN_A / REN_B        in   1   read enable, active high
// - BE_A / BE_B          in   4   byte-lane write enables
// - ADDR_A / ADDR_B      in   15  bit-granular address
// - WDATA_A / WDATA_B    in   32  write data
// - WPARITY_A/WPARITY_B  in   4   write parity bits
// - RDATA_A / RDATA_B    out  32  registered read data
// - RPARITY_A/RPARITY_B  out  4   registered read parity
// - Interface: one clock; reset is asynchronous and active-low (CLK, RST_N).
// BEHAVIOUR
// - Storage: 1024 words x 4 lanes. Lane i = {parity bit i, data bits [8i+7:8i]}.
// - Address map: word = ADDR[14:5].
//   - Width 36: all 4 lanes; ADDR[4:0] ignored.
//   - Width 18: lane pair {2*ADDR[4]+1, 2*ADDR[4]}; ADDR[3:0] ignored.
//   - Width 9: lane ADDR[4:3]; ADDR[2:0] ignored.
// - Port data placement by width:
//   - 36: WDATA[31:0] + WPARITY[3:0].
//   - 18: WDATA[15:0] + WPARITY[1:0]; BE[1:0] gates the two lanes.
//   - 9: WDATA[7:0] + WPARITY[0]; BE[0] gates the lane.
//   - Unused input bits are ignored. Unused output bits read 0.
// - Write: on posedge CLK with WEN=1, write each enabled lane. Lanes with BE=0 are unchanged. WEN=0: no write.
// - Read: on posedge CLK with REN=1, RDATA/RPARITY load the addressed word/lanes. Data is visible after that edge (1-cycle latency).
// - REN=0: read outputs hold their last value.
// - Same-port WEN and REN in the same cycle: read-first; the port returns the old contents.
// - Cross-port, same word, same cycle:
//   - Write vs read: the reader gets the old data.
//   - Both write, overlapping lanes: port A wins; non-overlapping lanes from both ports are written.
// - Reset: RST_N low immediately forces RDATA_A/B = 0 and RPARITY_A/B = 0 (asynchronous).
// - Reset leaves memory contents untouched. Writes and reads are blocked while RST_N = 0.
// - Release is synchronous-safe: first active edge after RST_N rises operates normally.
// - Memory power-up content: all zeros (simulation init).
// TESTING
// - Reset: RST_N=0 mid-run -> RDATA_A/B=0, RPARITY_A/B=0 at once. Release, then read a prior write -> data retained.
// - 36-bit A write/read: cycle 0 WEN_A=1, ADDR_A=0, BE_A=F, WDATA_A=0x12345678, WPARITY_A=0xA.
//   Cycle 1 WEN_A=0, REN_A=1 -> after edge RDATA_A=0x12345678, RPARITY_A=0xA.
//   Port B idle at ADDR_B=1 -> RDATA_B stays 0.
// - Byte enables: word 0 holds 0x12345678. Write 0xFFFFFFFF with BE_A=0101 -> read 0x12FF56FF. Parity lanes 0 and 2 updated only.
// - Cross-port: A writes 0xCAFEF00D to word 5 while B reads word 5 in the same cycle -> B gets the old value. B reads again next cycle -> 0xCAFEF00D.
// - Write collision: A writes 0x11111111 and B writes 0x22222222 to word 7, BE=F, same cycle -> readback 0x11111111.
// - Mixed width: A=36 writes 0xAABBCCDD to word 3. B=9 reads ADDR_B={3,2'b10,3'b0} -> RDATA_B=0x000000BB, REN_B low keeps it stable.

Source files
------------

// File: rtl/tdp_ram36k_sc.sv
// tdp_ram36k_sc: true dual-port 1024 x 36 block RAM on one clock.
// Each word is four 9-bit lanes {parity, byte}. Ports A and B read and write
// independently, each at a fixed width of 9, 18 or 36 bits. Reads are
// read-first, with one cycle of latency. On a lane written by both ports in
// the same cycle, port A wins. Reset clears only the read registers.
module tdp_ram36k_sc #(
  parameter int WRITE_WIDTH_A = 36,
  parameter int READ_WIDTH_A  = 36,
  parameter int WRITE_WIDTH_B = 36,
  parameter int READ_WIDTH_B  = 36
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wen_a_i,
  input  logic        ren_a_i,
  input  logic [3:0]  be_a_i,
  input  logic [14:0] addr_a_i,
  input  logic [31:0] wdata_a_i,
  input  logic [3:0]  wparity_a_i,
  output logic [31:0] rdata_a_o,
  output logic [3:0]  rparity_a_o,
  input  logic        wen_b_i,
  input  logic        ren_b_i,
  input  logic [3:0]  be_b_i,
  input  logic [14:0] addr_b_i,
  input  logic [31:0] wdata_b_i,
  input  logic [3:0]  wparity_b_i,
  output logic [31:0] rdata_b_o,
  output logic [3:0]  rparity_b_o
);

  // Reject unsupported widths, or a read width that differs from the write width, at elaboration.
  if (!((WRITE_WIDTH_A == 32'sd9) || (WRITE_WIDTH_A == 32'sd18) || (WRITE_WIDTH_A == 32'sd36))
      || (READ_WIDTH_A != WRITE_WIDTH_A)) begin : g_bad_width_a
    $error("tdp_ram36k_sc: illegal port A width configuration");
  end
  if (!((WRITE_WIDTH_B == 32'sd9) || (WRITE_WIDTH_B == 32'sd18) || (WRITE_WIDTH_B == 32'sd36))
      || (READ_WIDTH_B != WRITE_WIDTH_B)) begin : g_bad_width_b
    $error("tdp_ram36k_sc: illegal port B width configuration");
  end

  typedef logic [3:0][8:0] word_t;

  // Lanes of the addressed word that this port write touches.
  function automatic logic [3:0] lane_en(input int width, input logic [14:0] addr,
                                         input logic [3:0] be);
    logic [3:0] en;
    en = 4'b0000;
    case (width)
      32'sd36: en = be;
      32'sd18: en = addr[4] ? {be[1:0], 2'b00} : {2'b00, be[1:0]};
      32'sd9:  en[addr[4:3]] = be[0];
      default: en = 4'b0000;
    endcase
    return en;
  endfunction

  // Write data spread over all four lanes; lane_en selects which lanes are stored.
  function automatic word_t lane_data(input int width, input logic [31:0] wd,
                                      input logic [3:0] wp);
    word_t d;
    d = '0;
    case (width)
      32'sd36: d = {{wp[3], wd[31:24]}, {wp[2], wd[23:16]},
                    {wp[1], wd[15:8]},  {wp[0], wd[7:0]}};
      32'sd18: d = {{wp[1], wd[15:8]}, {wp[0], wd[7:0]},
                    {wp[1], wd[15:8]}, {wp[0], wd[7:0]}};
      32'sd9:  d = {4{wp[0], wd[7:0]}};
      default: d = '0;
    endcase
    return d;
  endfunction

  // Right-justify the addressed lanes into {parity[3:0], data[31:0]}; unused bits read 0.
  function automatic logic [35:0] read_sel(input int width, input logic [14:0] addr,
                                           input word_t w);
    logic [35:0] r;
    logic [8:0]  lo;
    logic [8:0]  hi;
    r  = 36'h0;
    lo = addr[4] ? w[2] : w[0];
    hi = addr[4] ? w[3] : w[1];
    case (width)
      32'sd36: r = {w[3][8], w[2][8], w[1][8], w[0][8],
                    w[3][7:0], w[2][7:0], w[1][7:0], w[0][7:0]};
      32'sd18: r = {2'b00, hi[8], lo[8], 16'h0000, hi[7:0], lo[7:0]};
      32'sd9:  r = {3'b000, w[addr[4:3]][8], 24'h000000, w[addr[4:3]][7:0]};
      default: r = 36'h0;
    endcase
    return r;
  endfunction

  // Storage powers up as zeros; reset never touches it.
  word_t       mem_q [0:1023] = '{default: '0};

  logic [3:0]  lane_we_a;
  logic [3:0]  lane_we_b;
  word_t       lane_wd_a;
  word_t       lane_wd_b;
  logic [35:0] rd_a_d;
  logic [35:0] rd_b_d;
  logic [35:0] rd_a_q;
  logic [35:0] rd_b_q;

  assign lane_we_a = lane_en(WRITE_WIDTH_A, addr_a_i, be_a_i);
  assign lane_we_b = lane_en(WRITE_WIDTH_B, addr_b_i, be_b_i);
  assign lane_wd_a = lane_data(WRITE_WIDTH_A, wdata_a_i, wparity_a_i);
  assign lane_wd_b = lane_data(WRITE_WIDTH_B, wdata_b_i, wparity_b_i);
  assign rd_a_d    = read_sel(READ_WIDTH_A, addr_a_i, mem_q[addr_a_i[14:5]]);
  assign rd_b_d    = read_sel(READ_WIDTH_B, addr_b_i, mem_q[addr_b_i[14:5]]);

  // Lane writes, blocked in reset; B is issued first so A's write to a shared lane lands last and wins.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      for (int l = 0; l < 32'sd4; l++) begin
        if (wen_b_i && lane_we_b[l]) begin
          mem_q[addr_b_i[14:5]][l] <= lane_wd_b[l];
        end
        if (wen_a_i && lane_we_a[l]) begin
          mem_q[addr_a_i[14:5]][l] <= lane_wd_a[l];
        end
      end
    end
  end

  // Port A read register: loads pre-write contents on REN, holds otherwise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_a_q <= 36'h0;
    end else if (ren_a_i) begin
      rd_a_q <= rd_a_d;
    end
  end

  // Port B read register: loads pre-write contents on REN, holds otherwise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_b_q <= 36'h0;
    end else if (ren_b_i) begin
      rd_b_q <= rd_b_d;
    end
  end

  assign rdata_a_o   = rd_a_q[31:0];
  assign rparity_a_o = rd_a_q[35:32];
  assign rdata_b_o   = rd_b_q[31:0];
  assign rparity_b_o = rd_b_q[35:32];

endmodule

// File: tb/tb_tdp_ram36k_sc.sv
// Bench for tdp_ram36k_sc. Two instances share one stimulus:
// u_dut0 has A at 36 bits and B at 9; u_dut1 has A at 18 and B at 36.
// The reference keeps the memory as a flat array of 9-bit lanes.
module tb_tdp_ram36k_sc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wen_a = 1'b0, ren_a = 1'b0, wen_b = 1'b0, ren_b = 1'b0;
  logic [3:0]  be_a = 4'h0, be_b = 4'h0, wpar_a = 4'h0, wpar_b = 4'h0;
  logic [14:0] addr_a = 15'h0, addr_b = 15'h0;
  logic [31:0] wdata_a = 32'h0, wdata_b = 32'h0;

  logic [31:0] rda0, rdb0, rda1, rdb1;
  logic [3:0]  rpa0, rpb0, rpa1, rpb1;
  logic [35:0] out_a0, out_b0, out_a1, out_b1;
  assign out_a0 = {rpa0, rda0};
  assign out_b0 = {rpb0, rdb0};
  assign out_a1 = {rpa1, rda1};
  assign out_b1 = {rpb1, rdb1};

  int checks = 0;
  int errors = 0;

  logic [8:0]  mdl [2][4096];
  logic [35:0] exp_a [2];
  logic [35:0] exp_b [2];

  tdp_ram36k_sc #(.WRITE_WIDTH_A(36), .READ_WIDTH_A(36), .WRITE_WIDTH_B(9), .READ_WIDTH_B(9)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .wen_a_i(wen_a), .ren_a_i(ren_a), .be_a_i(be_a), .addr_a_i(addr_a),
    .wdata_a_i(wdata_a), .wparity_a_i(wpar_a), .rdata_a_o(rda0), .rparity_a_o(rpa0),
    .wen_b_i(wen_b), .ren_b_i(ren_b), .be_b_i(be_b), .addr_b_i(addr_b),
    .wdata_b_i(wdata_b), .wparity_b_i(wpar_b), .rdata_b_o(rdb0), .rparity_b_o(rpb0));

  tdp_ram36k_sc #(.WRITE_WIDTH_A(18), .READ_WIDTH_A(18), .WRITE_WIDTH_B(36), .READ_WIDTH_B(36)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .wen_a_i(wen_a), .ren_a_i(ren_a), .be_a_i(be_a), .addr_a_i(addr_a),
    .wdata_a_i(wdata_a), .wparity_a_i(wpar_a), .rdata_a_o(rda1), .rparity_a_o(rpa1),
    .wen_b_i(wen_b), .ren_b_i(ren_b), .be_b_i(be_b), .addr_b_i(addr_b),
    .wdata_b_i(wdata_b), .wparity_b_i(wpar_b), .rdata_b_o(rdb1), .rparity_b_o(rpb1));

  always #5 clk = ~clk;

  function automatic int wid_a(int inst);
    return (inst == 0) ? 36 : 18;
  endfunction

  function automatic int wid_b(int inst);
    return (inst == 0) ? 9 : 36;
  endfunction

  function automatic logic [14:0] ad(int word, int sub);
    return 15'(word * 32 + sub);
  endfunction

  task automatic chk(string name, logic [35:0] act, logic [35:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, expv);
    end
  endtask

  // A port of width w covers w/9 consecutive lanes, aligned, at lane index ADDR[14:3].
  task automatic mdl_wr(int inst, int w, logic [14:0] addr, logic [3:0] be,
                        logic [31:0] wd, logic [3:0] wp);
    int nl;
    int base;
    nl = w / 9;
    base = int'(addr[14:3]) & ~(nl - 1);
    for (int k = 0; k < nl; k++)
      if (be[k]) mdl[inst][base + k] = {wp[k], wd[8*k +: 8]};
  endtask

  function automatic logic [35:0] mdl_rd(int inst, int w, logic [14:0] addr);
    int nl;
    int base;
    logic [35:0] r;
    nl = w / 9;
    base = int'(addr[14:3]) & ~(nl - 1);
    r = 36'h0;
    for (int k = 0; k < nl; k++) begin
      r[8*k +: 8] = mdl[inst][base + k][7:0];
      r[32 + k]   = mdl[inst][base + k][8];
    end
    return r;
  endfunction

  // Apply one cycle of inputs just after a falling edge and advance the reference to the next rise.
  task automatic drive(logic wa, logic ra, logic [3:0] bea, logic [14:0] aa, logic [31:0] da, logic [3:0] pa,
                       logic wb, logic rb, logic [3:0] beb, logic [14:0] ab, logic [31:0] db, logic [3:0] pb,
                       logic rst_v);
    logic [35:0] na;
    logic [35:0] nb;
    @(negedge clk);
    #1;
    wen_a = wa; ren_a = ra; be_a = bea; addr_a = aa; wdata_a = da; wpar_a = pa;
    wen_b = wb; ren_b = rb; be_b = beb; addr_b = ab; wdata_b = db; wpar_b = pb;
    rst_n = rst_v;
    for (int i = 0; i < 2; i++) begin
      if (!rst_v) begin
        exp_a[i] = 36'h0;
        exp_b[i] = 36'h0;
      end else begin
        na = ra ? mdl_rd(i, wid_a(i), aa) : exp_a[i];
        nb = rb ? mdl_rd(i, wid_b(i), ab) : exp_b[i];
        if (wb) mdl_wr(i, wid_b(i), ab, beb, db, pb);
        if (wa) mdl_wr(i, wid_a(i), aa, bea, da, pa);
        exp_a[i] = na;
        exp_b[i] = nb;
      end
    end
  endtask

  // Compare all four read ports against the reference at every falling edge.
  always @(negedge clk) begin
    chk("cmp_a0", out_a0, exp_a[0]);
    chk("cmp_b0", out_b0, exp_b[0]);
    chk("cmp_a1", out_a1, exp_a[1]);
    chk("cmp_b1", out_b1, exp_b[1]);
  end

  initial begin
    logic rv;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 4096; j++) mdl[i][j] = 9'h0;
      exp_a[i] = 36'h0;
      exp_b[i] = 36'h0;
    end
    #2;
    chk("reset_a0", out_a0, 36'h0);
    chk("reset_b0", out_b0, 36'h0);

    // 36-bit write then read; port B idles at word 1.
    drive(1'b1, 1'b0, 4'hF, ad(0, 0), 32'h12345678, 4'hA, 1'b0, 1'b0, 4'h0, ad(1, 0), 32'h0, 4'h0, 1'b1);
    drive(1'b0, 1'b1, 4'hF, ad(0, 0), 32'h0, 4'h0, 1'b0, 1'b0, 4'h0, ad(1, 0), 32'h0, 4'h0, 1'b1);
    @(posedge clk); #1;
    chk("a36_wr_rd", out_a0, 36'hA12345678);
    chk("b_idle", out_b0, 36'h0);

    // Byte enables 0101.
    drive(1'b1, 1'b0, 4'b0101, ad(0, 0), 32'hFFFFFFFF, 4'hF, 1'b0, 1'b0, 4'h0, ad(1, 0), 32'h0, 4'h0, 1'b1);
    drive(1'b0, 1'b1, 4'hF, ad(0, 0), 32'h0, 4'h0, 1'b0, 1'b0, 4'h0, ad(1, 0), 32'h0, 4'h0, 1'b1);
    @(posedge clk); #1;
    chk("be_mask", out_a0, 36'hF12FF56FF);

    // Cross-port write vs read on word 5: B first sees old lane 0, then the new one.
    drive(1'b1, 1'b0, 4'hF, ad(5, 0), 32'h01020304, 4'h0, 1'b0, 1'b0, 4'h0, ad(5, 0), 32'h0, 4'h0, 1'b1);
    drive(1'b1, 1'b0, 4'hF, ad(5, 0), 32'hCAFEF00D, 4'h5, 1'b0, 1'b1, 4'h0, ad(5, 0), 32'h0, 4'h0, 1'b1);
    @(posedge clk); #1;
    chk("xport_old", out_b0, 36'h000000004);
    drive(1'b0, 1'b0, 4'h0, ad(5, 0), 32'h0, 4'h0, 1'b0, 1'b1, 4'h0, ad(5, 0), 32'h0, 4'h0, 1'b1);
    @(posedge clk); #1;
    chk("xport_new", out_b0, 36'h10000000D);

    // Write collision on word 7: A wins.
    drive(1'b1, 1'b0, 4'hF, ad(7, 0), 32'h11111111, 4'h0, 1'b1, 1'b0, 4'hF, ad(7, 0), 32'h22222222, 4'hF, 1'b1);
    drive(1'b0, 1'b1, 4'h0, ad(7, 0), 32'h0, 4'h0, 1'b0, 1'b1, 4'h0, ad(7, 0), 32'h0, 4'h0, 1'b1);
    @(posedge clk); #1;
    chk("collide_a", out_a0, 36'h011111111);
    chk("collide_b", out_b0, 36'h000000011);

    // Mixed width: 9-bit B reads lane 2 of word 3, then holds it with REN low.
    drive(1'b1, 1'b0, 4'hF, ad(3, 0), 32'hAABBCCDD, 4'h0, 1'b0, 1'b0, 4'h0, ad(3, 0), 32'h0, 4'h0, 1'b1);
    drive(1'b0, 1'b0, 4'h0, ad(3, 0), 32'h0, 4'h0, 1'b0, 1'b1, 4'h0, ad(3, 16), 32'h0, 4'h0, 1'b1);
    @(posedge clk); #1;
    chk("mixed_b9", out_b0, 36'h0000000BB);
    drive(1'b0, 1'b0, 4'h0, ad(3, 0), 32'h0, 4'h0, 1'b0, 1'b0, 4'h0, ad(3, 0), 32'h0, 4'h0, 1'b1);
    drive(1'b0, 1'b0, 4'h0, ad(4, 0), 32'h0, 4'h0, 1'b0, 1'b0, 4'h0, ad(4, 8), 32'h0, 4'h0, 1'b1);
    @(posedge clk); #1;
    chk("b_hold", out_b0, 36'h0000000BB);

    // Mid-run reset with blocked write attempts; data survives.
    drive(1'b1, 1'b0, 4'hF, ad(0, 0), 32'hDEADBEEF, 4'h0, 1'b1, 1'b0, 4'hF, ad(0, 0), 32'h0, 4'h0, 1'b0);
    #1;
    chk("rst_now_a0", out_a0, 36'h0);
    chk("rst_now_b0", out_b0, 36'h0);
    chk("rst_now_a1", out_a1, 36'h0);
    chk("rst_now_b1", out_b1, 36'h0);
    drive(1'b1, 1'b1, 4'hF, ad(0, 0), 32'hDEADBEEF, 4'h0, 1'b1, 1'b1, 4'hF, ad(0, 0), 32'h0, 4'h0, 1'b0);
    drive(1'b0, 1'b1, 4'h0, ad(0, 0), 32'h0, 4'h0, 1'b0, 1'b0, 4'h0, ad(0, 0), 32'h0, 4'h0, 1'b1);
    @(posedge clk); #1;
    chk("retain", out_a0, 36'hF12FF56FF);
    chk("mdl_pin", exp_a[0], 36'hF12FF56FF);

    // Randomized traffic over eight words to provoke collisions, with occasional resets.
    rv = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if (!rv) rv = 1'b1;
      else if ($urandom_range(0, 199) == 0) rv = 1'b0;
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
            ad($urandom_range(0, 7), $urandom_range(0, 31)), 32'($urandom), 4'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
            ad($urandom_range(0, 7), $urandom_range(0, 31)), 32'($urandom), 4'($urandom), rv);
    end
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
